// File: rtl/spu_pkg.sv
// Shared SPU definitions: reducer state encoding and summary byte indices.
package spu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    EMIT  = 2'd2
  } spu_state_e;

  localparam int SUMMARY_BYTES = 5;
  localparam int IDX_W         = $clog2(SUMMARY_BYTES);

  typedef logic [IDX_W-1:0] idx_t;

  localparam idx_t IDX_SUM_HI = idx_t'(0);
  localparam idx_t IDX_SUM_LO = idx_t'(1);
  localparam idx_t IDX_MIN    = idx_t'(2);
  localparam idx_t IDX_MAX    = idx_t'(3);
  localparam idx_t IDX_CNT    = idx_t'(SUMMARY_BYTES - 1);

endpackage

// File: rtl/spu_result_reducer.sv
// Reduces a batch of SPU result bytes into a 5-byte summary: sum (hi, lo), min, max, count.
module spu_result_reducer
  import spu_pkg::*;
#(
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  input  logic [LEN_W-1:0] batch_len,
  input  logic             flush,
  output logic             out_valid,
  output logic [7:0]       out_data,
  input  logic             out_ready,
  output logic             busy
);

  localparam int SUM_W = 8 + LEN_W;
  localparam int CNT_W = LEN_W + 1;
  localparam logic [CNT_W-1:0] FULL_LEN = {1'b1, {LEN_W{1'b0}}};

  spu_state_e       state_q, state_d;
  logic [SUM_W-1:0] sum_q, sum_d;
  logic [7:0]       min_q, min_d;
  logic [7:0]       max_q, max_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] len_q, len_d;
  idx_t             idx_q, idx_d;
  logic             outValid_q, outValid_d;
  logic [7:0]       outData_q, outData_d;
  logic             live_q;
  logic             inFire;
  logic             outFire;
  logic [CNT_W-1:0] lenNew;

  function automatic logic [7:0] selByte(input idx_t i, input logic [SUM_W-1:0] s,
                                         input logic [7:0] mn, input logic [7:0] mx,
                                         input logic [CNT_W-1:0] c);
    logic [15:0] sExt;
    logic [7:0]  cExt;
    sExt = 16'(s);
    cExt = 8'(c);
    case (i)
      IDX_SUM_HI: selByte = sExt[15:8];
      IDX_SUM_LO: selByte = sExt[7:0];
      IDX_MIN:    selByte = mn;
      IDX_MAX:    selByte = mx;
      IDX_CNT:    selByte = cExt;
      default:    selByte = 8'h00;
    endcase
  endfunction

  // live_q keeps in_ready low until the first edge after reset releases
  assign in_ready  = live_q && (state_q != EMIT) && !flush;
  assign inFire    = in_valid && in_ready;
  assign outFire   = outValid_q && out_ready;
  assign out_valid = outValid_q;
  assign out_data  = outData_q;
  assign busy      = (state_q != IDLE);
  assign lenNew    = (batch_len == '0) ? FULL_LEN : {1'b0, batch_len};

  always_comb begin
    state_d    = state_q;
    sum_d      = sum_q;
    min_d      = min_q;
    max_d      = max_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    idx_d      = idx_q;
    outValid_d = outValid_q;
    outData_d  = outData_q;
    case (state_q)
      IDLE: begin
        if (inFire) begin
          len_d = lenNew;
          sum_d = SUM_W'(in_data);
          min_d = in_data;
          max_d = in_data;
          cnt_d = CNT_W'(1);
          if (lenNew == CNT_W'(1)) begin
            state_d    = EMIT;
            idx_d      = IDX_SUM_HI;
            outValid_d = 1'b1;
            outData_d  = selByte(IDX_SUM_HI, sum_d, min_d, max_d, cnt_d);
          end else begin
            state_d = ACCUM;
          end
        end
      end
      ACCUM: begin
        if (inFire) begin
          sum_d = sum_q + SUM_W'(in_data);
          min_d = (in_data < min_q) ? in_data : min_q;
          max_d = (in_data > max_q) ? in_data : max_q;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_d == len_q) begin
            state_d    = EMIT;
            idx_d      = IDX_SUM_HI;
            outValid_d = 1'b1;
            outData_d  = selByte(IDX_SUM_HI, sum_d, min_d, max_d, cnt_d);
          end
        end
      end
      EMIT: begin
        if (outFire) begin
          if (idx_q == IDX_CNT) begin
            state_d    = IDLE;
            idx_d      = '0;
            outValid_d = 1'b0;
            outData_d  = '0;
          end else begin
            idx_d     = idx_q + idx_t'(1);
            outData_d = selByte(idx_d, sum_q, min_q, max_q, cnt_q);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Flush wins over everything, including an accept or transfer in the same cycle
    if (flush) begin
      state_d    = IDLE;
      sum_d      = '0;
      min_d      = '0;
      max_d      = '0;
      cnt_d      = '0;
      idx_d      = '0;
      outValid_d = 1'b0;
      outData_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sum_q      <= '0;
      min_q      <= '0;
      max_q      <= '0;
      cnt_q      <= '0;
      len_q      <= '0;
      idx_q      <= '0;
      outValid_q <= 1'b0;
      outData_q  <= '0;
      live_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sum_q      <= sum_d;
      min_q      <= min_d;
      max_q      <= max_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      outValid_q <= outValid_d;
      outData_q  <= outData_d;
      live_q     <= 1'b1;
    end
  end

endmodule

// File: tb/tb_spu_result_reducer.sv
// Self-checking bench for spu_result_reducer against a batch-level reference model.
module tb_spu_result_reducer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready;
  logic [3:0] batch_len = 4'd0;
  logic       flush = 1'b0;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready = 1'b0;
  logic       busy;

  int assertCount = 0;
  int failCount = 0;

  int         modelCnt = 0;
  int         modelLen = 0;
  int         modelSum = 0;
  logic [7:0] modelMin = 8'h00;
  logic [7:0] modelMax = 8'h00;
  logic [7:0] expQ[$];

  int readyMode = 0;
  bit xferThisCycle = 1'b0;
  bit liveExp = 1'b0;
  int cycleNum = 0;
  int lastIdx4Edge = 0;
  int lastAcceptEdge = 0;

  spu_result_reducer #(.LEN_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .batch_len (batch_len),
    .flush     (flush),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleNum <= cycleNum + 1;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Reference model: collects a batch and, once complete, queues its five summary bytes
  task automatic modelAccept(input logic [7:0] d, input int len);
    if (modelCnt == 0) begin
      modelLen = (len == 0) ? 16 : len;
      modelSum = d;
      modelMin = d;
      modelMax = d;
    end else begin
      modelSum += d;
      if (d < modelMin) modelMin = d;
      if (d > modelMax) modelMax = d;
    end
    modelCnt++;
    if (modelCnt == modelLen) begin
      expQ.push_back(8'(modelSum / 256));
      expQ.push_back(8'(modelSum % 256));
      expQ.push_back(modelMin);
      expQ.push_back(modelMax);
      expQ.push_back(8'(modelCnt));
      modelCnt = 0;
    end
  endtask

  task automatic applyStimulus(input logic [7:0] d, input int len);
    bit done;
    bit expReady;
    done = 1'b0;
    @(negedge clk);
    in_valid  = 1'b1;
    in_data   = d;
    batch_len = (modelCnt == 0) ? 4'(len) : 4'($urandom);
    for (int w = 0; w < 200 && !done; w++) begin
      #1;
      expReady = liveExp && !flush && (expQ.size() == 0) && !xferThisCycle;
      checkOutput("in_ready", in_ready, expReady);
      if (in_ready) begin
        lastAcceptEdge = cycleNum + 1;
        @(posedge clk);
        modelAccept(d, len);
        #1 in_valid = 1'b0;
        done = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    if (!done) begin
      checkOutput("accept_timeout", 0, 1);
      in_valid = 1'b0;
    end
  endtask

  task automatic waitDrain();
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      #1;
      if (expQ.size() == 0 && !xferThisCycle) break;
    end
    checkOutput("drain", expQ.size(), 0);
  endtask

  task automatic doFlush();
    @(negedge clk);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h77;
    #1 checkOutput("flush_in_ready", in_ready, 0);
    @(posedge clk);
    modelCnt = 0;
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
  endtask

  // Output monitor: drives out_ready and checks every presented byte against the model
  always @(negedge clk) begin
    xferThisCycle = 1'b0;
    case (readyMode)
      0:       out_ready = 1'b1;
      1:       out_ready = ~out_ready;
      2:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = (expQ.size() > 3);
    endcase
    if (!rst_n) begin
      checkOutput("rst_out_valid", out_valid, 0);
    end else begin
      checkOutput("out_valid", out_valid, expQ.size() > 0);
      if (out_valid && expQ.size() > 0) begin
        checkOutput(out_ready ? "out_data" : "out_hold", out_data, expQ[0]);
        if (out_ready) begin
          void'(expQ.pop_front());
          xferThisCycle = 1'b1;
          if (expQ.size() == 0) lastIdx4Edge = cycleNum + 1;
        end
      end
      checkOutput("busy", busy, (modelCnt > 0) || (expQ.size() > 0) || xferThisCycle);
    end
  end

  initial begin
    int len;
    int n;
    logic [7:0] d;

    #1;
    checkOutput("rst_in_ready", in_ready, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_out_data", out_data, 0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    #1 checkOutput("in_ready_pre_edge", in_ready, 0);
    @(posedge clk);
    #1 liveExp = 1'b1;
    checkOutput("in_ready_live", in_ready, 1);

    $display("[TB] basic batch of three");
    readyMode = 0;
    applyStimulus(8'h10, 3);
    applyStimulus(8'h05, 3);
    applyStimulus(8'hFF, 3);
    @(negedge clk);
    #1 checkOutput("emit_in_ready", in_ready, 0);
    waitDrain();

    $display("[TB] full batch of sixteen 0xFF");
    for (int i = 0; i < 16; i++) applyStimulus(8'hFF, 0);
    waitDrain();

    $display("[TB] single sample with stalling consumer");
    readyMode = 1;
    applyStimulus(8'h2A, 1);
    waitDrain();

    $display("[TB] flush mid-batch");
    readyMode = 0;
    applyStimulus(8'h11, 4);
    applyStimulus(8'h22, 4);
    doFlush();
    applyStimulus(8'h03, 2);
    applyStimulus(8'h01, 2);
    waitDrain();

    $display("[TB] reset during summary byte 2");
    readyMode = 3;
    applyStimulus(8'h30, 3);
    applyStimulus(8'h31, 3);
    applyStimulus(8'h32, 3);
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      #2;
      if (out_valid && expQ.size() == 3) break;
    end
    checkOutput("reached_idx2", expQ.size(), 3);
    rst_n = 1'b0;
    expQ.delete();
    modelCnt = 0;
    liveExp = 1'b0;
    xferThisCycle = 1'b0;
    #1;
    checkOutput("mid_rst_out_valid", out_valid, 0);
    checkOutput("mid_rst_busy", busy, 0);
    checkOutput("mid_rst_in_ready", in_ready, 0);
    checkOutput("mid_rst_out_data", out_data, 0);
    readyMode = 0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1 liveExp = 1'b1;
    applyStimulus(8'h80, 2);
    applyStimulus(8'h7F, 2);
    waitDrain();

    $display("[TB] input held across summary boundary");
    applyStimulus(8'h40, 2);
    applyStimulus(8'h41, 2);
    applyStimulus(8'h50, 3);
    checkOutput("bubble_edge", lastAcceptEdge, lastIdx4Edge + 1);
    applyStimulus(8'h51, 3);
    applyStimulus(8'h4F, 3);
    waitDrain();

    $display("[TB] randomized batches");
    readyMode = 2;
    for (int b = 0; b < 25; b++) begin
      len = $urandom_range(0, 15);
      n = (len == 0) ? 16 : len;
      for (int i = 0; i < n; i++) begin
        d = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
        applyStimulus(d, len);
      end
    end
    waitDrain();

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/spu_result_reducer.md
SPU_RESULT_REDUCER -- requirements
Module: spu_result_reducer

Interface
REQ-001 SHALL have parameter LEN_W, default 4, width of batch_len; a batch length of 0 means 2**LEN_W samples.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on the rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port in_valid  input  1  an SPU result byte is present.
REQ-005 SHALL have port in_data  input  8  SPU result byte: Manhattan distance or box area, {high nibble, low nibble}.
REQ-006 SHALL have port in_ready  output  1  the reducer accepts in_data this cycle.
REQ-007 SHALL have port batch_len  input  LEN_W  number of samples per batch; sampled only when the first sample of a batch is accepted.
REQ-008 SHALL have port flush  input  1  synchronous abort; the partial batch or summary is discarded.
REQ-009 SHALL have port out_valid  output  1  a summary byte is present.
REQ-010 SHALL have port out_data  output  8  summary byte.
REQ-011 SHALL have port out_ready  input  1  the consumer takes out_data this cycle.
REQ-012 SHALL have port busy  output  1  high in ACCUM or EMIT.

Function
REQ-013 SHALL transfer an input only when in_valid and in_ready are both high; an output transfers only when out_valid and out_ready are both high.
REQ-014 SHALL implement the states IDLE, ACCUM and EMIT; in_ready = 1 in IDLE and ACCUM with flush low, otherwise 0; out_valid = 1 only in EMIT.
REQ-015 SHALL, on an IDLE accept, latch len = (batch_len==0 ? 2**LEN_W : batch_len), and set sum=in_data, min=in_data, max=in_data, cnt=1; the next state is EMIT if len==1, otherwise ACCUM.
REQ-016 SHALL, on an ACCUM accept, set sum+=in_data, min=min(min,in_data), max=max(max,in_data) (unsigned), cnt+=1; when the new cnt equals len the next state is EMIT.
REQ-017 SHALL hold sum at 8+LEN_W bits unsigned, which cannot overflow by construction; cnt is LEN_W+1 bits.
REQ-018 SHALL emit exactly 5 bytes in EMIT, in this order:
- idx0 = sum[15:8], zero-extended to 16 bits
- idx1 = sum[7:0]
- idx2 = min
- idx3 = max
- idx4 = cnt[7:0], zero-extended
REQ-019 SHALL hold out_data stable while out_valid is high and out_ready is low; idx advances only on an output transfer.
REQ-020 SHALL go from EMIT to IDLE in the cycle after idx4 transfers; a new batch is accepted no earlier than the next cycle (one bubble).
REQ-021 SHALL register outputs; the first summary byte is valid in the cycle after the last sample is accepted (latency 1).
REQ-022 SHALL, on flush high in any state, go to IDLE on the next edge, clear sum/min/max/cnt/idx and drop out_valid; a simultaneous in_valid is not accepted.
REQ-023 SHALL ignore batch_len changes during ACCUM/EMIT.

Reset
REQ-024 SHALL, while rst_n is low, immediately force state=IDLE, sum=0, min=0, max=0, cnt=0, idx=0, out_valid=0, out_data=0, busy=0 and in_ready=0; in_ready rises the first cycle after rst_n deasserts.
REQ-025 SHALL let reset mid-batch or mid-EMIT discard all data with no partial output afterwards.

Structure
REQ-026 SHALL take the state enum (IDLE/ACCUM/EMIT), SUMMARY_BYTES=5 and the idx constants from shared package spu_pkg.
REQ-027 SHALL be a single module; the sum/min/max datapath is inline, no sub-module.

Verification
REQ-028 SHALL cover: batch_len=3, inputs 0x10, 0x05, 0xFF back-to-back, out_ready=1 -> bytes 0x01, 0x14, 0x05, 0xFF, 0x03, and in_ready=0 during EMIT.
REQ-029 SHALL cover: batch_len=0 (16 samples), all 0xFF -> bytes 0x0F, 0xF0, 0xFF, 0xFF, 0x10.
REQ-030 SHALL cover: batch_len=1, input 0x2A, out_ready toggled 1/0 every cycle -> bytes 0x00, 0x2A, 0x2A, 0x2A, 0x01, each held stable while stalled.
REQ-031 SHALL cover: flush asserted after 2 of 4 samples, then batch_len=2 with 0x03, 0x01 -> only bytes 0x00, 0x04, 0x01, 0x03, 0x02 appear.
REQ-032 SHALL cover: rst_n pulsed low during EMIT idx2 -> out_valid=0 immediately, busy=0, and the next batch is reduced correctly.
REQ-033 SHALL cover: in_valid held high across the EMIT-to-IDLE boundary -> the first sample is accepted exactly one cycle after idx4 transfers and no sample is lost.
